// File: rtl/decoder_arbiter_pkg.sv
// Shared definitions for the decoder arbiter: FSM encodings, decoder enable
// codes and a one-hot helper.
package decoder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [1:0] ENA_ON  = 2'b10;
    localparam logic [1:0] ENA_OFF = 2'b11;

    localparam int unsigned NUM_REQ   = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned HOLD_W    = 8;
    localparam int unsigned GAP_W     = 4;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/decoder_arbiter_rr_pick8.sv
// Round-robin picker: first set request at or after ptr, wrapping 7->0.
module rr_pick8
    import decoder_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters, with a
// bounded hold per grant and a mandatory disabled gap between grants.
//
// state | meaning
// IDLE  | decoder disabled, waiting for any request
// GRANT | decoder enabled on oSel, holdCnt counting toward MAX_HOLD
// GAP   | decoder disabled, gapCnt counting toward GAP_CYCLES
module decoder_arbiter
    import decoder_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned GAP_CYCLES = 1
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] iReq,
    output logic [IDX_W-1:0]   oSel,
    output logic [1:0]         oEna,
    output logic [NUM_REQ-1:0] oGrant,
    output logic               oBusy,
    output logic               oTimeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [1:0]          ena_q, ena_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                req_held;
    logic                hold_done;
    logic                grant_release;
    logic                gap_done;
    logic                grant_start;

    rr_pick8 u_pick (
        .req   (iReq),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // The last gap cycle arbitrates exactly like IDLE, so a waiting requester
    // sees only GAP_CYCLES disabled cycles between grants.
    assign req_held      = iReq[sel_q];
    assign hold_done     = (hold_cnt_q == HOLD_LAST);
    assign grant_release = (state_q == GRANT) && (!req_held || hold_done);
    assign gap_done      = (state_q == GAP) && (gap_cnt_q == GAP_LAST);
    assign grant_start   = ((state_q == IDLE) || gap_done) && pick_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sel_q      <= '0;
            ena_q      <= ENA_OFF;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sel_q      <= sel_d;
            ena_q      <= ena_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_start) begin
                    state_d    = GRANT;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (grant_release) begin
                    state_d   = GAP;
                    ptr_d     = sel_q + 1'b1;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (grant_start) begin
                    state_d    = GRANT;
                    hold_cnt_d = '0;
                end else if (gap_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_d     = sel_q;
        ena_d     = ena_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        if (grant_start) begin
            sel_d   = pick_idx;
            ena_d   = ENA_ON;
            grant_d = onehot8(pick_idx);
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                GRANT: begin
                    busy_d = 1'b1;
                    if (grant_release) begin
                        ena_d     = ENA_OFF;
                        grant_d   = '0;
                        // A drop coinciding with the limit counts as a drop.
                        timeout_d = req_held;
                    end
                end
                GAP: begin
                    ena_d   = ENA_OFF;
                    grant_d = '0;
                    busy_d  = !gap_done;
                end
                default: begin
                    ena_d   = ENA_OFF;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign oSel     = sel_q;
    assign oEna     = ena_q;
    assign oGrant   = grant_q;
    assign oBusy    = busy_q;
    assign oTimeout = timeout_q;

endmodule
